// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset controller.
// Holds the FSM state encoding, the reset-cause codes and the counter width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        POWER_ON  = 2'd0,
        LOCK_LOSS = 2'd1,
        BUTTON    = 2'd2,
        SOFTWARE  = 2'd3
    } cause_t;

    // Level the board button rests at (active-low, released = 1).
    localparam logic BTN_IDLE = 1'b1;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    // Bits needed to count 0 .. max(a, b)-1; never less than one bit.
    function automatic int unsigned count_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stability counter.
// The output only follows the synchronised level after CYCLES equal samples.
module debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned W = $clog2(CYCLES);

    logic [1:0]   sync;
    logic [W-1:0] cnt;

    // Counting only runs while the sample disagrees with the output, so a
    // sample flipping back to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= {2{BTN_IDLE}};
            cnt   <= '0;
            level <= BTN_IDLE;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == W'(CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: waits for PLL lock and a released button, then drops
// the reset channels one by one; lock loss, button or software re-assert all.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS     = 3,
    parameter int unsigned LOCK_WAIT_CYCLES = 32,
    parameter int unsigned STAGE_GAP_CYCLES = 16,
    parameter int unsigned DEBOUNCE_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    locked_i,
    input  logic                    btn_n_i,
    input  logic                    sw_reset_i,
    output logic [NUM_CHANNELS-1:0] reset_o,
    output logic                    ready_o,
    output logic [1:0]              cause_o,
    output logic [7:0]              reset_count_o,
    output state_t                  dbg_state
);

    localparam int unsigned CW = count_width(LOCK_WAIT_CYCLES, STAGE_GAP_CYCLES);

    logic [1:0] lock_sync;
    logic       locked;
    logic       btn_level;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [NUM_CHANNELS-1:0] chan, chan_nx;
    logic                    ready, ready_nx;
    cause_t                  cause, cause_nx;
    logic [7:0]              count, count_nx;

    logic   good;
    logic   fault;
    cause_t fault_cause;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], locked_i};
        end
    end

    assign locked = lock_sync[1];

    debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst_n(reset_n_i),
        .raw  (btn_n_i),
        .level(btn_level)
    );

    assign good        = locked && btn_level;
    assign fault       = !locked || !btn_level || sw_reset_i;
    assign fault_cause = !locked ? LOCK_LOSS : (!btn_level ? BUTTON : SOFTWARE);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= HOLD;
            cnt   <= '0;
            chan  <= '1;
            ready <= 1'b0;
            cause <= POWER_ON;
            count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            chan  <= chan_nx;
            ready <= ready_nx;
            cause <= cause_nx;
            count <= count_nx;
        end
    end

    // Channels are released by shifting zeros in from bit 0, so the release
    // order is fixed and "all released" is simply chan == 0.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chan_nx  = chan;
        ready_nx = ready;
        cause_nx = cause;
        count_nx = count;
        case (state)
            HOLD: begin
                chan_nx  = '1;
                ready_nx = 1'b0;
                cnt_nx   = '0;
                if (good) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (!good) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_WAIT_CYCLES - 1)) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                    chan_nx  = chan << 1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RELEASE, RUN: begin
                if (fault) begin
                    state_nx = HOLD;
                    chan_nx  = '1;
                    ready_nx = 1'b0;
                    cnt_nx   = '0;
                    cause_nx = fault_cause;
                    count_nx = (count == COUNT_MAX) ? count : count + 8'd1;
                end else if (state == RELEASE) begin
                    if (chan == '0) begin
                        state_nx = RUN;
                        ready_nx = 1'b1;
                    end else if (cnt == CW'(STAGE_GAP_CYCLES - 1)) begin
                        chan_nx = chan << 1;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = HOLD;
                chan_nx  = '1;
                ready_nx = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    assign reset_o       = chan;
    assign ready_o       = ready;
    assign cause_o       = cause;
    assign reset_count_o = count;
    assign dbg_state     = state;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller for the SoC top level, replacing the fixed lock-wait counter and raw button OR. It synchronises PLL lock and the board button, debounces the button and accepts a software reset request. It drives N active-high reset channels, all asserted together and released in a fixed staggered order, and reports the cause of the last reset. It sits in the top level between the PLL/button pins and the `xgsoc`, video and USB reset inputs.

## Interface
- `NUM_CHANNELS`, default 3: number of reset outputs; minimum 1.
- `LOCK_WAIT_CYCLES`, default 32: cycles that lock and button must stay good before channel 0 is released; minimum 1.
- `STAGE_GAP_CYCLES`, default 16: cycles between successive channel releases; minimum 1.
- `DEBOUNCE_CYCLES`, default 1024: cycles the synchronised button must stay stable before the debounced value changes; minimum 2.
- `clk` input, 1 bit: single clock for the whole block.
- `reset_n_i` input, 1 bit: asynchronous, active-low block reset.
- `locked_i` input, 1 bit: PLL lock, asynchronous; passes through a 2-FF synchroniser.
- `btn_n_i` input, 1 bit: board button, active-low, asynchronous; passes through a 2-FF synchroniser, then the debouncer.
- `sw_reset_i` input, 1 bit: software reset request; one-cycle pulse, synchronous to `clk`.
- `reset_o` output, NUM_CHANNELS bits: active-high resets; bit 0 is released first.
- `ready_o` output, 1 bit: high once all channels are released.
- `cause_o` output, 2 bits: last reset cause. 0 = power-on, 1 = lock loss, 2 = button, 3 = software.
- `reset_count_o` output, 8 bits: count of resets since `reset_n_i`; saturates at 255.

## Operation
- While `reset_n_i` is low, all outputs hold their reset values:
  - `reset_o` all ones, `ready_o` 0, `cause_o` 0, `reset_count_o` 0.
  - FSM in HOLD, lock synchroniser 0, button synchroniser and debounced value 1 (released).
- HOLD:
  - All channels asserted.
  - Go to WAIT when synced lock = 1 and debounced button = 1.
- WAIT:
  - All channels asserted; counts LOCK_WAIT_CYCLES cycles.
  - If lock or button goes bad, return to HOLD. No cause update and no count change.
  - `sw_reset_i` is ignored.
  - When the count completes, go to RELEASE.
- RELEASE:
  - Deassert `reset_o[0]` on entry.
  - Deassert each next channel STAGE_GAP_CYCLES cycles after the previous one.
  - After `reset_o[NUM_CHANNELS-1]` falls, go to RUN.
- RUN: `ready_o` = 1.
- Fault handling in RELEASE or RUN:
  - Fault conditions: synced lock falls, a debounced press, or `sw_reset_i` = 1.
  - On the next edge, go to HOLD, drive all `reset_o` to 1 and `ready_o` to 0.
  - Update `cause_o` and increment `reset_count_o`, saturating at 255.
- Simultaneous faults: priority is lock loss, then button, then software. Only one count increment.
- A held button keeps the FSM in HOLD. Release is measured from the debounced release.
- Debouncer: the debounced value takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples. Any change in the sample restarts the count.
- Internal counters are wide enough for the larger of the wait and gap counts.

## Timing
- Lock-sync latency is 2 cycles. Button latency is 2 cycles plus DEBOUNCE_CYCLES.
- Reference sequence, with lock high and button released from `reset_n_i` deassertion (before edge 0):
  - Synced lock = 1 after edge 2; HOLD to WAIT at edge 3.
  - `reset_o[0]` falls at edge 3+L.
  - `reset_o[k]` falls at edge 3+L+k·G.
  - `ready_o` rises at edge 3+L+(N−1)·G+1.
  - Defaults give falls at edges 35, 51, 67 and ready at edge 68.
- Fault to all-reset latency is 1 edge after the synchronised or debounced event.
- Reset mid-operation: asynchronous assertion of `reset_n_i` forces all outputs to their reset values immediately.

## Structure
- Package `reset_seq_pkg`:
  - `state_t` enum: HOLD, WAIT, RELEASE, RUN.
  - `cause_t` enum: POWER_ON=0, LOCK_LOSS=1, BUTTON=2, SOFTWARE=3.
- Sub-module `debounce`, with parameter CYCLES: contains the 2-FF synchroniser and the stability counter; outputs the debounced level.
- Top-level integration: `xgsoc` takes `reset_o[0]`, video takes `reset_o[1]`, USB takes `reset_o[2]`.

## Test plan
- Power-on with lock high and defaults → `reset_o` falls at edges 35/51/67, `ready_o` rises at edge 68, `cause_o` = 0, `reset_count_o` = 0.
- Drop `locked_i` in RUN → all `reset_o` = 1 within 3 edges, `cause_o` = 1, count = 1. Restore lock → same staged release.
- Button press with 5-cycle glitches, DEBOUNCE_CYCLES = 8 → no reset. A 20-cycle stable press → reset, `cause_o` = 2. Channel release starts LOCK_WAIT_CYCLES after the debounced release.
- `sw_reset_i` pulse while `reset_o` = 3'b100 (mid-RELEASE) → all channels reassert, `cause_o` = 3. The same pulse in WAIT → ignored.
- Lock loss, button press and sw pulse on the same cycle → `cause_o` = 1, count increments by exactly 1. 300 software resets → count holds at 255.
- `reset_n_i` low mid-RELEASE → outputs at reset values without a clock edge. Also run NUM_CHANNELS = 1 → `ready_o` rises 1 edge after `reset_o[0]` falls.
